// File: rtl/sap_pkg.sv
// Shared encodings for the SAP datapath: bus-source selects, opcodes,
// sequencer states and the bundle of control strobes.
package sap_pkg;

  localparam logic [2:0] SEL_PC  = 3'd0;
  localparam logic [2:0] SEL_IR  = 3'd1;
  localparam logic [2:0] SEL_ACC = 3'd2;
  localparam logic [2:0] SEL_ALU = 3'd3;
  localparam logic [2:0] SEL_MEM = 3'd4;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    TS_IDLE = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_T3   = 3'd3,
    TS_T4   = 3'd4,
    TS_T5   = 3'd5,
    TS_T6   = 3'd6,
    TS_HALT = 3'd7
  } tstate_e;

  typedef struct packed {
    logic [2:0] bus_sel;
    logic       mar_load;
    logic       pc_inc;
    logic       pc_load;
    logic       ir_load;
    logic       acc_load;
    logic       b_load;
    logic       alu_sub;
    logic       out_load;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/sap_tstate_counter.sv
// Six-phase fetch/execute sequencer state. Owns IDLE/T1..T6/HALT and the
// run / halt decisions; HALT is left only through reset.
module sap_tstate_counter
  import sap_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    run,
  input  logic    is_hlt,
  output tstate_e t_state
);

  tstate_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TS_IDLE: if (run) state_d = TS_T1;
      TS_T1:   state_d = TS_T2;
      TS_T2:   state_d = TS_T3;
      TS_T3:   state_d = TS_T4;
      TS_T4:   state_d = is_hlt ? TS_HALT : TS_T5;
      TS_T5:   state_d = TS_T6;
      // run is only looked at here, so the running instruction always completes
      TS_T6:   state_d = run ? TS_T1 : TS_IDLE;
      TS_HALT: state_d = TS_HALT;
      default: state_d = TS_IDLE;
    endcase
  end

  assign t_state = state_q;

endmodule

// File: rtl/sap_controller.sv
// SAP control sequencer: decodes the registered T-state and IR opcode into
// the bus-source select and per-register load/increment strobes.
module sap_controller
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [2:0] bus_sel,
  output logic       mar_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ir_load,
  output logic       acc_load,
  output logic       b_load,
  output logic       alu_sub,
  output logic       out_load,
  output logic       instr_done,
  output logic       halted,
  output logic [2:0] t_state
);

  tstate_e ts;
  ctrl_t   c;
  logic    is_hlt;

  assign is_hlt = (opcode == OP_HLT);

  sap_tstate_counter u_tstate (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .is_hlt  (is_hlt),
    .t_state (ts)
  );

  always_comb begin
    c         = '0;
    c.bus_sel = SEL_MEM;
    case (ts)
      TS_T1: begin c.bus_sel = SEL_PC;  c.mar_load = 1'b1; end
      TS_T2: c.pc_inc = 1'b1;
      TS_T3: begin c.bus_sel = SEL_MEM; c.ir_load = 1'b1; end
      TS_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin c.bus_sel = SEL_IR;  c.mar_load = 1'b1; end
          OP_JMP:                 begin c.bus_sel = SEL_IR;  c.pc_load  = 1'b1; end
          OP_OUT:                 begin c.bus_sel = SEL_ACC; c.out_load = 1'b1; end
          default: ;
        endcase
      end
      TS_T5: begin
        case (opcode)
          OP_LDA: c.acc_load = 1'b1;
          OP_ADD: c.b_load   = 1'b1;
          OP_SUB: begin c.b_load = 1'b1; c.alu_sub = 1'b1; end
          default: ;
        endcase
      end
      TS_T6: begin
        c.instr_done = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          c.bus_sel  = SEL_ALU;
          c.acc_load = 1'b1;
          c.alu_sub  = (opcode == OP_SUB);
        end
      end
      TS_HALT: c.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus_sel    = c.bus_sel;
  assign mar_load   = c.mar_load;
  assign pc_inc     = c.pc_inc;
  assign pc_load    = c.pc_load;
  assign ir_load    = c.ir_load;
  assign acc_load   = c.acc_load;
  assign b_load     = c.b_load;
  assign alu_sub    = c.alu_sub;
  assign out_load   = c.out_load;
  assign instr_done = c.instr_done;
  assign halted     = c.halted;
  assign t_state    = ts;

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: each task walks an instruction cycle by
// cycle and compares every output against hand-derived values at negedge.
module tb_sap_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic [2:0] bus_sel, t_state;
  logic       mar_load, pc_inc, pc_load, ir_load, acc_load, b_load;
  logic       alu_sub, out_load, instr_done, halted;

  int n_cmp = 0;
  int n_err = 0;

  sap_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .bus_sel(bus_sel), .mar_load(mar_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .ir_load(ir_load), .acc_load(acc_load), .b_load(b_load), .alu_sub(alu_sub),
    .out_load(out_load), .instr_done(instr_done), .halted(halted), .t_state(t_state)
  );

  always #5 clk = ~clk;

  // {t_state, bus_sel, mar, pc_inc, pc_load, ir, acc, b, alu_sub, out, done, halted}
  logic [15:0] obs;
  assign obs = {t_state, bus_sel, mar_load, pc_inc, pc_load, ir_load, acc_load,
                b_load, alu_sub, out_load, instr_done, halted};

  localparam logic [9:0] MAR  = 10'b10_0000_0000;
  localparam logic [9:0] PCI  = 10'b01_0000_0000;
  localparam logic [9:0] PCL  = 10'b00_1000_0000;
  localparam logic [9:0] IRL  = 10'b00_0100_0000;
  localparam logic [9:0] ACC  = 10'b00_0010_0000;
  localparam logic [9:0] BL   = 10'b00_0001_0000;
  localparam logic [9:0] SUB  = 10'b00_0000_1000;
  localparam logic [9:0] OUTL = 10'b00_0000_0100;
  localparam logic [9:0] DONE = 10'b00_0000_0010;
  localparam logic [9:0] HLT  = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b0;

  function automatic logic [15:0] ev(input logic [2:0] ts, input logic [2:0] sel,
                                     input logic [9:0] st);
    return {ts, sel, st};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; opcode = 4'h0;
    #3;
    n_cmp++;
    if (obs !== ev(3'd0, 3'd4, NONE)) begin
      n_err++; $display("FAIL reset_async got %h want %h", obs, ev(3'd0, 3'd4, NONE));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== ev(3'd0, 3'd4, NONE)) begin
      n_err++; $display("FAIL reset_idle got %h want %h", obs, ev(3'd0, 3'd4, NONE));
    end
  endtask

  // run is dropped right after T1: the instruction still finishes, then IDLE
  task automatic test_lda;
    logic [15:0] exp [7];
    exp = '{ev(3'd1, 3'd0, MAR), ev(3'd2, 3'd4, PCI), ev(3'd3, 3'd4, IRL),
            ev(3'd4, 3'd1, MAR), ev(3'd5, 3'd4, ACC), ev(3'd6, 3'd4, DONE),
            ev(3'd0, 3'd4, NONE)};
    opcode = 4'b0000; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL lda[%0d] got %h want %h", i, obs, exp[i]);
      end
      run = 1'b0;
    end
  endtask

  task automatic test_sub;
    logic [15:0] exp [7];
    exp = '{ev(3'd1, 3'd0, MAR), ev(3'd2, 3'd4, PCI), ev(3'd3, 3'd4, IRL),
            ev(3'd4, 3'd1, MAR), ev(3'd5, 3'd4, BL | SUB),
            ev(3'd6, 3'd3, ACC | SUB | DONE), ev(3'd0, 3'd4, NONE)};
    opcode = 4'b0010; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL sub[%0d] got %h want %h", i, obs, exp[i]);
      end
      run = 1'b0;
    end
  endtask

  // JMP then OUT with run high across the boundary: no idle cycle between
  task automatic test_back_to_back;
    logic [15:0] exp [13];
    exp = '{ev(3'd1, 3'd0, MAR), ev(3'd2, 3'd4, PCI), ev(3'd3, 3'd4, IRL),
            ev(3'd4, 3'd1, PCL), ev(3'd5, 3'd4, NONE), ev(3'd6, 3'd4, DONE),
            ev(3'd1, 3'd0, MAR), ev(3'd2, 3'd4, PCI), ev(3'd3, 3'd4, IRL),
            ev(3'd4, 3'd2, OUTL), ev(3'd5, 3'd4, NONE), ev(3'd6, 3'd4, DONE),
            ev(3'd0, 3'd4, NONE)};
    opcode = 4'b0011; run = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL b2b[%0d] got %h want %h", i, obs, exp[i]);
      end
      if (i == 6) begin opcode = 4'b1110; run = 1'b0; end
    end
  endtask

  task automatic test_halt;
    logic [15:0] exp [8];
    exp = '{ev(3'd1, 3'd0, MAR), ev(3'd2, 3'd4, PCI), ev(3'd3, 3'd4, IRL),
            ev(3'd4, 3'd4, NONE), ev(3'd7, 3'd4, HLT), ev(3'd7, 3'd4, HLT),
            ev(3'd7, 3'd4, HLT), ev(3'd7, 3'd4, HLT)};
    opcode = 4'b1111; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL hlt[%0d] got %h want %h", i, obs, exp[i]);
      end
      if (i >= 4) run = ~run;
    end
    run = 1'b0;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (obs !== ev(3'd0, 3'd4, NONE)) begin
      n_err++; $display("FAIL hlt_reset got %h want %h", obs, ev(3'd0, 3'd4, NONE));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== ev(3'd0, 3'd4, NONE)) begin
      n_err++; $display("FAIL hlt_release got %h want %h", obs, ev(3'd0, 3'd4, NONE));
    end
  endtask

  // reset lands in the middle of ADD's T5; acc_load of T6 must never appear
  task automatic test_reset_mid;
    logic [15:0] exp [5];
    exp = '{ev(3'd1, 3'd0, MAR), ev(3'd2, 3'd4, PCI), ev(3'd3, 3'd4, IRL),
            ev(3'd4, 3'd1, MAR), ev(3'd5, 3'd4, BL)};
    opcode = 4'b0001; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp[i]) begin
        n_err++; $display("FAIL add[%0d] got %h want %h", i, obs, exp[i]);
      end
    end
    rst_n = 1'b0; run = 1'b0;
    #1;
    n_cmp++;
    if (obs !== ev(3'd0, 3'd4, NONE)) begin
      n_err++; $display("FAIL mid_reset got %h want %h", obs, ev(3'd0, 3'd4, NONE));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== ev(3'd0, 3'd4, NONE)) begin
        n_err++; $display("FAIL post_reset[%0d] got %h want %h", i, obs, ev(3'd0, 3'd4, NONE));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
